id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX). Captures the 11-bit decoded control word and the ID operands.
- Detects load-use hazards against the instruction currently in EX and inserts a nop bubble when one is found.
- Honours EX back-pressure (multi-cycle FPU) and branch flush.
- Drives the ID/IF stall line and keeps a saturating count of inserted load-use bubbles.

Parameters:
- XLEN, 32, width of pc, operand and immediate datapaths
- CNT_W, 16, width of the load-use bubble counter

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- control_signal_id  in  11  decoded control word; bit10 alusrc, 9 memtoreg, 8:7 regwrite (01 int RF, 10 FPU RF, 00 none), 6 memread, 5 memwrite, 4 branch, 3:2 alu_op, 1 rs1_fpu, 0 rs2_fpu
- valid_id  in  1  ID holds a real instruction
- pc_id  in  XLEN  instruction PC
- rs1_data_id, rs2_data_id  in  XLEN  register-file read data
- imm_id  in  XLEN  immediate
- rs1_addr_id, rs2_addr_id, rd_addr_id  in  5  register indices
- funct3_id  in  3  instruction funct3
- funct7_id  in  7  instruction funct7
- ex_ready  in  1  EX accepts a new instruction this cycle
- flush_ex  in  1  taken branch resolved in EX; kill ID contents
- control_signal_ex  out  11  latched control word
- valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rs1_addr_ex, rs2_addr_ex, rd_addr_ex, funct3_ex, funct7_ex  out  widths as ID counterparts  latched fields
- stall_id  out  1  hold PC and IF/ID register
- bubble_count  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rstn low, asynchronous): every registered output is 0. This includes control_signal_ex=11'b0 (nop), valid_ex=0 and bubble_count=0. Reset mid-stall drops held contents.
- Bubble: control_signal_ex=0, valid_ex=0, all other fields 0.
- uses_rs1: control_signal_id != 0.
- uses_rs2: control_signal_id != 0 and (alusrc==0 or memwrite==1).
- dest_fpu: regwrite_ex==10. dest_int: regwrite_ex==01.
- Source match for rs1: rs1_addr_id==rd_addr_ex, and either (rs1_fpu==1 and dest_fpu) or (rs1_fpu==0 and dest_int and rd_addr_ex!=0). rs2 is identical, using rs2_fpu.
- load_use is asserted when all of the following hold:
  - valid_ex
  - memread_ex==1
  - valid_id
  - (uses_rs1 and the rs1 match) or (uses_rs2 and the rs2 match)
- Integer x0 never hazards; FPU f0 does.
- Register update priority, each rising edge:
  1. flush_ex=1: load bubble.
  2. ex_ready=0: hold all registers unchanged.
  3. load_use=1: load bubble; increment bubble_count.
  4. Otherwise: load all ID fields. If valid_id=0, load a bubble instead.
- stall_id (combinational) = !flush_ex && (!ex_ready || load_use). Flush never stalls; the flushed ID instruction is discarded upstream.
- Latency: one cycle ID to EX, with no combinational path from data inputs to EX outputs.
- bubble_count increments by 1 only under rule 3. It saturates at 2^CNT_W−1 and never wraps.
- The same instruction may cause at most one bubble. After the bubble, EX holds a nop, so load_use deasserts and the instruction advances on the next edge.
- Operands latched during a hold are not refreshed. EX forwarding resolves them using the latched addresses.

Test Plan:
- Reset mid-operation: register loaded with lw; assert rstn=0 between edges → all outputs 0 immediately, bubble_count=0.
- Int load-use: EX=lw (11011000000), rd_ex=5; ID=add (00010001000), rs2_addr=5 → stall_id=1; next edge EX=nop, bubble_count=1; following edge EX=add, stall_id=0.
- No false hazards:
  - ID=addi (10010000000), rs2_addr field=5, EX lw rd=5, rs1≠5 → no stall.
  - EX lw rd=0, ID rs1=0 → no stall.
- FPU load-use: EX=flw (11101000000), rd_ex=3; ID=fadd (00100001111), rs1=3 → stall. Same case with ID=addi rs1=3 (int RF) → no stall.
- Back-pressure: ex_ready=0 for 3 cycles with ID=add → EX outputs frozen, stall_id=1, bubble_count unchanged. Then ex_ready=1 → add loads.
- Flush vs. concurrent events: flush_ex=1 together with load_use=1 and ex_ready=0 → EX=bubble, stall_id=0, bubble_count unchanged. Saturation: preload at 16'hFFFF, add one more load-use → stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage boundary: decoded ID fields in, latched EX fields out, plus stall/flush/ready.
// Pure wiring bundle; no storage or latency of its own.
// Back-pressure travels on ex_ready (EX -> stage) and stall_id (stage -> ID/IF).
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // decode side
    logic [10:0]     control_signal_id;
    logic            valid_id;
    logic [XLEN-1:0] pc_id;
    logic [XLEN-1:0] rs1_data_id;
    logic [XLEN-1:0] rs2_data_id;
    logic [XLEN-1:0] imm_id;
    logic [4:0]      rs1_addr_id;
    logic [4:0]      rs2_addr_id;
    logic [4:0]      rd_addr_id;
    logic [2:0]      funct3_id;
    logic [6:0]      funct7_id;

    // execute side control
    logic            ex_ready;
    logic            flush_ex;

    // latched fields seen by execute
    logic [10:0]     control_signal_ex;
    logic            valid_ex;
    logic [XLEN-1:0] pc_ex;
    logic [XLEN-1:0] rs1_data_ex;
    logic [XLEN-1:0] rs2_data_ex;
    logic [XLEN-1:0] imm_ex;
    logic [4:0]      rs1_addr_ex;
    logic [4:0]      rs2_addr_ex;
    logic [4:0]      rd_addr_ex;
    logic [2:0]      funct3_ex;
    logic [6:0]      funct7_ex;

    // status back to decode/fetch
    logic            stall_id;
    logic [CNT_W-1:0] bubble_count;

    // surrounding pipeline (decode, execute, hazard consumers)
    modport master (
        output control_signal_id, valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
               rs1_addr_id, rs2_addr_id, rd_addr_id, funct3_id, funct7_id,
               ex_ready, flush_ex,
        input  control_signal_ex, valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
               rs1_addr_ex, rs2_addr_ex, rd_addr_ex, funct3_ex, funct7_ex,
               stall_id, bubble_count
    );

    // the ID/EX pipeline register itself
    modport slave (
        input  control_signal_id, valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
               rs1_addr_id, rs2_addr_id, rd_addr_id, funct3_id, funct7_id,
               ex_ready, flush_ex,
        output control_signal_ex, valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
               rs1_addr_ex, rs2_addr_ex, rd_addr_ex, funct3_ex, funct7_ex,
               stall_id, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion and saturating bubble counter.
// Latency: one cycle ID to EX; outputs come straight from flops.
// Back-pressure: holds while ex_ready=0 and stalls ID; flush_ex overrides both and never stalls.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic [10:0]     ctrl;
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } ex_regs_t;

    ex_regs_t         ex_q;
    ex_regs_t         id_word;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic uses_rs1;
    logic uses_rs2;
    logic dest_fpu;
    logic dest_int;
    logic rs1_match;
    logic rs2_match;
    logic load_use;

    // Pack the ID side into one word so the register update is a single assignment.
    always_comb begin
        id_word          = '0;
        id_word.ctrl     = bus.control_signal_id;
        id_word.valid    = bus.valid_id;
        id_word.pc       = bus.pc_id;
        id_word.rs1_data = bus.rs1_data_id;
        id_word.rs2_data = bus.rs2_data_id;
        id_word.imm      = bus.imm_id;
        id_word.rs1_addr = bus.rs1_addr_id;
        id_word.rs2_addr = bus.rs2_addr_id;
        id_word.rd_addr  = bus.rd_addr_id;
        id_word.funct3   = bus.funct3_id;
        id_word.funct7   = bus.funct7_id;
    end

    // Load-use detection against the instruction now in EX. Integer x0 is
    // hard-wired so it never hazards; FPU f0 is a real register and does.
    always_comb begin
        uses_rs1  = (bus.control_signal_id != 11'b0);
        uses_rs2  = uses_rs1 && (!bus.control_signal_id[10] || bus.control_signal_id[5]);
        dest_fpu  = (ex_q.ctrl[8:7] == 2'b10);
        dest_int  = (ex_q.ctrl[8:7] == 2'b01);
        rs1_match = (bus.rs1_addr_id == ex_q.rd_addr) &&
                    ( bus.control_signal_id[1] ? dest_fpu
                                               : (dest_int && (ex_q.rd_addr != 5'd0)));
        rs2_match = (bus.rs2_addr_id == ex_q.rd_addr) &&
                    ( bus.control_signal_id[0] ? dest_fpu
                                               : (dest_int && (ex_q.rd_addr != 5'd0)));
        load_use  = ex_q.valid && ex_q.ctrl[6] && bus.valid_id &&
                    ((uses_rs1 && rs1_match) || (uses_rs2 && rs2_match));
    end

    // Pipeline register: flush beats hold, hold beats bubble, bubble beats advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else if (bus.flush_ex) begin
            ex_q <= '0;
        end else if (!bus.ex_ready) begin
            ex_q <= ex_q;
        end else if (load_use) begin
            ex_q <= '0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
        end else if (bus.valid_id) begin
            ex_q <= id_word;
        end else begin
            ex_q <= '0;
        end
    end

    // Stall ID/IF while EX is busy or a bubble is going in; a flush discards ID instead.
    always_comb begin
        bus.stall_id = !bus.flush_ex && (!bus.ex_ready || load_use);
    end

    // Drive the EX-side fields straight from the flops.
    always_comb begin
        bus.control_signal_ex = ex_q.ctrl;
        bus.valid_ex          = ex_q.valid;
        bus.pc_ex             = ex_q.pc;
        bus.rs1_data_ex       = ex_q.rs1_data;
        bus.rs2_data_ex       = ex_q.rs2_data;
        bus.imm_ex            = ex_q.imm;
        bus.rs1_addr_ex       = ex_q.rs1_addr;
        bus.rs2_addr_ex       = ex_q.rs2_addr;
        bus.rd_addr_ex        = ex_q.rd_addr;
        bus.funct3_ex         = ex_q.funct3;
        bus.funct7_ex         = ex_q.funct7;
        bus.bubble_count      = bubble_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: hazards, hold, flush, async reset, counter saturation.
// A second instance with a 2-bit counter sees identical stimulus to reach saturation quickly.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_id_ex_stage;

    localparam logic [10:0] LW   = 11'b11011000000;
    localparam logic [10:0] ADD  = 11'b00010001000;
    localparam logic [10:0] ADDI = 11'b10010000000;
    localparam logic [10:0] FLW  = 11'b11101000000;
    localparam logic [10:0] FADD = 11'b00100001111;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    id_ex_stage_if #(.XLEN(32), .CNT_W(16)) bus ();
    id_ex_stage_if #(.XLEN(32), .CNT_W(2))  bus2 ();

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    id_ex_stage #(.XLEN(32), .CNT_W(2))  dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

    assign bus2.control_signal_id = bus.control_signal_id;
    assign bus2.valid_id          = bus.valid_id;
    assign bus2.pc_id             = bus.pc_id;
    assign bus2.rs1_data_id       = bus.rs1_data_id;
    assign bus2.rs2_data_id       = bus.rs2_data_id;
    assign bus2.imm_id            = bus.imm_id;
    assign bus2.rs1_addr_id       = bus.rs1_addr_id;
    assign bus2.rs2_addr_id       = bus.rs2_addr_id;
    assign bus2.rd_addr_id        = bus.rd_addr_id;
    assign bus2.funct3_id         = bus.funct3_id;
    assign bus2.funct7_id         = bus.funct7_id;
    assign bus2.ex_ready          = bus.ex_ready;
    assign bus2.flush_ex          = bus.flush_ex;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a valid instruction in ID; operand data is derived from the PC.
    task automatic set_id(input logic [10:0] c, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [31:0] pc);
        bus.control_signal_id = c;
        bus.valid_id          = 1'b1;
        bus.pc_id             = pc;
        bus.rs1_data_id       = pc ^ 32'h1111_0000;
        bus.rs2_data_id       = pc ^ 32'h2222_0000;
        bus.imm_id            = pc + 32'd8;
        bus.rs1_addr_id       = r1;
        bus.rs2_addr_id       = r2;
        bus.rd_addr_id        = rd;
        bus.funct3_id         = 3'd5;
        bus.funct7_id         = 7'h20;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        bus.control_signal_id = '0;
        bus.valid_id          = 1'b0;
        bus.pc_id             = '0;
        bus.rs1_data_id       = '0;
        bus.rs2_data_id       = '0;
        bus.imm_id            = '0;
        bus.rs1_addr_id       = '0;
        bus.rs2_addr_id       = '0;
        bus.rd_addr_id        = '0;
        bus.funct3_id         = '0;
        bus.funct7_id         = '0;
        bus.ex_ready          = 1'b1;
        bus.flush_ex          = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", bus.control_signal_ex, 0);
        chk("rst_valid", bus.valid_ex, 0);
        chk("rst_cnt", bus.bubble_count, 0);
        chk("rst_pc", bus.pc_ex, 0);
        chk("rst_stall", bus.stall_id, 0);
        rstn = 1'b1;

        // integer load-use: lw x5 then add using x5 as rs2
        set_id(LW, 5'd1, 5'd0, 5'd5, 32'h100);
        tick();
        chk("lw_ctrl", bus.control_signal_ex, LW);
        chk("lw_rd", bus.rd_addr_ex, 5);
        chk("lw_valid", bus.valid_ex, 1);
        chk("lw_pc", bus.pc_ex, 32'h100);
        chk("lw_rs1d", bus.rs1_data_ex, 32'h1111_0100);
        chk("lw_imm", bus.imm_ex, 32'h108);
        chk("lw_f3", bus.funct3_ex, 5);
        set_id(ADD, 5'd1, 5'd5, 5'd6, 32'h104);
        #1;
        chk("int_lu_stall", bus.stall_id, 1);
        tick();
        chk("bub_ctrl", bus.control_signal_ex, 0);
        chk("bub_valid", bus.valid_ex, 0);
        chk("bub_rd", bus.rd_addr_ex, 0);
        chk("bub_pc", bus.pc_ex, 0);
        chk("bub_cnt", bus.bubble_count, 1);
        chk("bub_stall", bus.stall_id, 0);
        tick();
        chk("add_ctrl", bus.control_signal_ex, ADD);
        chk("add_rd", bus.rd_addr_ex, 6);
        chk("add_pc", bus.pc_ex, 32'h104);
        chk("add_rs2a", bus.rs2_addr_ex, 5);
        chk("add_stall", bus.stall_id, 0);

        // no false hazards: addi ignores rs2 field, x0 never hazards
        set_id(LW, 5'd2, 5'd0, 5'd5, 32'h108);
        tick();
        chk("lw2_ctrl", bus.control_signal_ex, LW);
        set_id(ADDI, 5'd2, 5'd5, 5'd7, 32'h10c);
        #1;
        chk("addi_rs2_nostall", bus.stall_id, 0);
        set_id(LW, 5'd2, 5'd0, 5'd0, 32'h110);
        tick();
        chk("lw_x0_rd", bus.rd_addr_ex, 0);
        chk("lw_x0_ctrl", bus.control_signal_ex, LW);
        set_id(ADD, 5'd0, 5'd0, 5'd8, 32'h114);
        #1;
        chk("x0_nostall", bus.stall_id, 0);

        // FPU load-use, and an integer reader of the same index
        set_id(FLW, 5'd2, 5'd0, 5'd3, 32'h118);
        tick();
        chk("flw_ctrl", bus.control_signal_ex, FLW);
        chk("flw_rd", bus.rd_addr_ex, 3);
        set_id(FADD, 5'd3, 5'd7, 5'd4, 32'h11c);
        #1;
        chk("fpu_lu_stall", bus.stall_id, 1);
        set_id(ADDI, 5'd3, 5'd0, 5'd4, 32'h120);
        #1;
        chk("fpu_int_nostall", bus.stall_id, 0);
        set_id(FADD, 5'd3, 5'd7, 5'd4, 32'h11c);
        tick();
        chk("fbub_ctrl", bus.control_signal_ex, 0);
        chk("fbub_cnt", bus.bubble_count, 2);
        tick();
        chk("fadd_ctrl", bus.control_signal_ex, FADD);
        chk("fadd_pc", bus.pc_ex, 32'h11c);

        // back-pressure: EX frozen for three cycles
        set_id(ADD, 5'd1, 5'd2, 5'd9, 32'h200);
        bus.ex_ready = 1'b0;
        #1;
        chk("bp_stall0", bus.stall_id, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ctrl", bus.control_signal_ex, FADD);
            chk("bp_pc", bus.pc_ex, 32'h11c);
            chk("bp_cnt", bus.bubble_count, 2);
            chk("bp_stall", bus.stall_id, 1);
        end
        bus.ex_ready = 1'b1;
        tick();
        chk("bp_rel_ctrl", bus.control_signal_ex, ADD);
        chk("bp_rel_rd", bus.rd_addr_ex, 9);
        chk("bp_rel_pc", bus.pc_ex, 32'h200);

        // flush with concurrent load-use and back-pressure
        set_id(LW, 5'd1, 5'd0, 5'd5, 32'h204);
        tick();
        chk("lw3_ctrl", bus.control_signal_ex, LW);
        set_id(ADD, 5'd1, 5'd5, 5'd6, 32'h208);
        bus.ex_ready = 1'b0;
        bus.flush_ex = 1'b1;
        #1;
        chk("flush_stall", bus.stall_id, 0);
        tick();
        chk("flush_ctrl", bus.control_signal_ex, 0);
        chk("flush_valid", bus.valid_ex, 0);
        chk("flush_cnt", bus.bubble_count, 2);
        chk("flush_cnt2", bus2.bubble_count, 2);
        bus.flush_ex = 1'b0;
        bus.ex_ready = 1'b1;

        // asynchronous reset in the middle of a stall
        set_id(LW, 5'd1, 5'd0, 5'd5, 32'h300);
        tick();
        chk("lw4_ctrl", bus.control_signal_ex, LW);
        set_id(ADD, 5'd1, 5'd5, 5'd6, 32'h304);
        #1;
        chk("pre_rst_stall", bus.stall_id, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_ctrl", bus.control_signal_ex, 0);
        chk("arst_valid", bus.valid_ex, 0);
        chk("arst_pc", bus.pc_ex, 0);
        chk("arst_cnt", bus.bubble_count, 0);
        chk("arst_cnt2", bus2.bubble_count, 0);
        chk("arst_stall", bus.stall_id, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // counter saturation: the 2-bit instance must stop at 3
        for (int i = 0; i < 4; i++) begin
            set_id(LW, 5'd1, 5'd0, 5'd5, 32'h400);
            tick();
            set_id(ADD, 5'd1, 5'd5, 5'd6, 32'h404);
            tick();
            chk("sat_cnt16", bus.bubble_count, i + 1);
            chk("sat_cnt2", bus2.bubble_count, (i + 1 > 3) ? 3 : i + 1);
        end

        // an empty ID slot loads a bubble
        bus.valid_id = 1'b0;
        tick();
        tick();
        chk("novalid_ctrl", bus.control_signal_ex, 0);
        chk("novalid_valid", bus.valid_ex, 0);
        chk("novalid_cnt", bus.bubble_count, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
